// File: rtl/ciphertext_serializer.sv
// ciphertext_serializer
// Captures the full ciphertext once the encryptor reports completion, then
// streams it out MSB-first, one byte per valid/ready transfer. The block is
// one-shot: once every byte has been accepted it stays in DONE until reset.
//
// Ports:
//   iClk           system clock, rising edge
//   iRst           asynchronous active-low reset
//   iCiphertext    ciphertext, sampled only on the load edge
//   iEncrypt_done  encryptor completion level
//   iReady         consumer accepts oByte on this edge
//   oByte          current output byte
//   oValid         oByte holds an unaccepted byte
//   oByte_counter  number of bytes accepted so far
//   oSend_done     every byte accepted (latched until reset)
//
// state | meaning
// IDLE  | waiting for iEncrypt_done, shift register empty
// SEND  | presenting bytes, one per accepted transfer
// DONE  | all bytes accepted, terminal until reset
module ciphertext_serializer #(
  parameter int MSG_SIZE = 512,
  parameter int BYTE_W   = 8,
  localparam int NBYTES  = MSG_SIZE / 8,
  localparam int CW      = $clog2(NBYTES) + 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [MSG_SIZE-1:0] iCiphertext,
  input  logic                iEncrypt_done,
  input  logic                iReady,
  output logic [BYTE_W-1:0]   oByte,
  output logic                oValid,
  output logic [CW-1:0]       oByte_counter,
  output logic                oSend_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [MSG_SIZE-1:0] shift_reg;
  logic                load;
  logic                xfer;
  logic                last_byte;

  assign last_byte = (oByte_counter == CW'(NBYTES - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    xfer       = 1'b0;
    oValid     = 1'b0;
    oSend_done = 1'b0;
    case (state)
      IDLE: begin
        if (iEncrypt_done) begin
          load       = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        oValid = 1'b1;
        if (iReady) begin
          xfer = 1'b1;
          if (last_byte) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        oSend_done = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The head byte is always the top of the shift register; zero-fill on
  // shifting means the register is empty again once the stream completes.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      shift_reg     <= '0;
      oByte_counter <= '0;
    end else if (load) begin
      shift_reg     <= iCiphertext;
    end else if (xfer) begin
      shift_reg     <= {shift_reg[MSG_SIZE-BYTE_W-1:0], {BYTE_W{1'b0}}};
      oByte_counter <= oByte_counter + CW'(1);
    end
  end

  assign oByte = shift_reg[MSG_SIZE-1 -: BYTE_W];

endmodule

// File: tb/tb_ciphertext_serializer.sv
module tb_ciphertext_serializer;

  localparam int MSG = 512;
  localparam int N   = MSG / 8;
  localparam int CW  = 7;

  logic           iClk = 1'b0;
  logic           iRst = 1'b0;
  logic [MSG-1:0] iCiphertext = '0;
  logic           iEncrypt_done = 1'b0;
  logic           iReady = 1'b0;
  logic [7:0]     oByte;
  logic           oValid;
  logic [CW-1:0]  oByte_counter;
  logic           oSend_done;

  int checks = 0;
  int errors = 0;

  ciphertext_serializer #(.MSG_SIZE(MSG)) dut (
    .iClk(iClk), .iRst(iRst), .iCiphertext(iCiphertext),
    .iEncrypt_done(iEncrypt_done), .iReady(iReady), .oByte(oByte),
    .oValid(oValid), .oByte_counter(oByte_counter), .oSend_done(oSend_done)
  );

  always #5 iClk = ~iClk;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a captured message plus the number of bytes accepted.
  logic [MSG-1:0] m_data = '0;
  int             m_idx = 0;
  bit             m_loaded = 1'b0;

  always @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      m_loaded = 1'b0;
      m_idx    = 0;
    end else if (!m_loaded) begin
      if (iEncrypt_done) begin
        m_loaded = 1'b1;
        m_data   = iCiphertext;
        m_idx    = 0;
      end
    end else if (m_idx < N && iReady) begin
      m_idx++;
    end
  end

  function automatic logic [7:0] model_byte(input int k);
    return m_data[MSG-1-8*k -: 8];
  endfunction

  always @(negedge iClk) begin
    chk("valid", oValid, (m_loaded && m_idx < N) ? 1 : 0);
    chk("send_done", oSend_done, (m_loaded && m_idx == N) ? 1 : 0);
    chk("counter", oByte_counter, m_loaded ? m_idx : 0);
    if (m_loaded && m_idx < N) chk("byte", oByte, model_byte(m_idx));
  end

  task automatic step(input bit r);
    @(posedge iClk);
    #1;
    iReady = r;
  endtask

  task automatic do_reset(input bit enc);
    iRst = 1'b0;
    iEncrypt_done = enc;
    iReady = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b1;
  endtask

  function automatic logic [MSG-1:0] ramp_data();
    logic [MSG-1:0] d;
    for (int k = 0; k < N; k++) d[MSG-1-8*k -: 8] = 8'(k);
    return d;
  endfunction

  function automatic logic [MSG-1:0] rand_data();
    logic [MSG-1:0] d;
    for (int w = 0; w < MSG / 32; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  task automatic wait_done(input int mode, input int budget);
    int c = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (!oSend_done && c < budget) begin
      case (mode)
        0: step(1'b1);
        1: step(pat[c % 4]);
        default: step(1'($urandom_range(0, 1)));
      endcase
      c++;
    end
    chk("done_within_budget", oSend_done, 1);
  endtask

  initial begin
    // Reset values
    do_reset(1'b0);
    chk("rst_valid", oValid, 0);
    chk("rst_counter", oByte_counter, 0);
    chk("rst_byte", oByte, 0);
    chk("rst_done", oSend_done, 0);

    // No backpressure, ramp data
    iCiphertext = ramp_data();
    repeat (10) step(1'b1);
    iEncrypt_done = 1'b1;
    step(1'b1);
    chk("nobp_first_valid", oValid, 1);
    chk("nobp_first_byte", oByte, 8'h00);
    repeat (32) step(1'b1);
    chk("nobp_mid_byte", oByte, 8'h20);
    chk("nobp_mid_counter", oByte_counter, 32);
    repeat (31) step(1'b1);
    chk("nobp_last_byte", oByte, 8'h3f);
    chk("nobp_last_valid", oValid, 1);
    step(1'b1);
    chk("nobp_done", oSend_done, 1);
    chk("nobp_valid_low", oValid, 0);
    chk("nobp_counter", oByte_counter, 64);

    // Terminal DONE: inputs keep changing, nothing moves
    for (int i = 0; i < 100; i++) begin
      iCiphertext = rand_data();
      step(1'b1);
    end
    chk("term_done", oSend_done, 1);
    chk("term_counter", oByte_counter, 64);

    // Backpressure 1,0,0,1
    do_reset(1'b0);
    iCiphertext = ramp_data();
    step(1'b0);
    iEncrypt_done = 1'b1;
    wait_done(1, 1000);
    chk("bp_counter", oByte_counter, 64);

    // Late ready
    do_reset(1'b0);
    iCiphertext = ramp_data();
    iEncrypt_done = 1'b1;
    step(1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      chk("late_byte", oByte, 8'h00);
      chk("late_valid", oValid, 1);
      chk("late_counter", oByte_counter, 0);
    end
    wait_done(0, 200);

    // Reset mid-send, then done already high at reset release
    do_reset(1'b0);
    iCiphertext = ramp_data();
    iEncrypt_done = 1'b1;
    begin
      int c = 0;
      while (oByte_counter != 30 && c < 200) begin
        step(1'b1);
        c++;
      end
    end
    chk("mid_counter_reached", oByte_counter, 30);
    #2;
    iRst = 1'b0;
    #1;
    chk("async_valid", oValid, 0);
    chk("async_counter", oByte_counter, 0);
    chk("async_byte", oByte, 0);
    chk("async_done", oSend_done, 0);
    iCiphertext = '1;
    do_reset(1'b1);
    step(1'b1);
    chk("restart_valid", oValid, 1);
    chk("restart_byte", oByte, 8'hff);
    chk("restart_counter", oByte_counter, 0);
    wait_done(0, 200);

    // Randomized runs, including encrypt_done dropping mid-send
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      iCiphertext = rand_data();
      repeat ($urandom_range(0, 5)) step(1'($urandom_range(0, 1)));
      iEncrypt_done = 1'b1;
      step(1'($urandom_range(0, 1)));
      iCiphertext = rand_data();
      if (r % 2 == 1) iEncrypt_done = 1'b0;
      wait_done(2, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ciphertext_serializer.md
Name: ciphertext_serializer

Overview:
- Downstream stage of the XOR encryption block.
- Captures the full MSG_SIZE-bit ciphertext once the encryptor flags completion, then streams it out one byte per transfer on an 8-bit valid/ready interface toward the output pins.
- One-shot per reset, matching the encryptor's latched done flag.

Parameters:
- MSG_SIZE, 512, ciphertext width in bits; must be a multiple of 8.
- BYTE_W, 8, output word width; fixed at 8, not to be overridden.

Ports:
- iClk  input  1  single system clock; all state updates on rising edge.
- iRst  input  1  asynchronous, active-low reset.
- iCiphertext  input  MSG_SIZE  ciphertext from the encryptor; sampled only on the load cycle.
- iEncrypt_done  input  1  encryptor completion flag; level, stays high until reset.
- iReady  input  1  consumer ready for the current byte.
- oByte  output  8  current output byte.
- oValid  output  1  oByte holds a valid, not-yet-accepted byte.
- oByte_counter  output  clog2(MSG_SIZE/8)+1  bytes accepted so far, 0..MSG_SIZE/8.
- oSend_done  output  1  all bytes accepted; latches high.

Behaviour:
- Reset (iRst low, any time, asynchronous):
  - State goes to IDLE.
  - Shift register, oByte, oValid, oByte_counter and oSend_done all clear to 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - oValid=0.
  - On a clock edge with iEncrypt_done=1: load iCiphertext into the internal shift register, go to SEND.
  - oValid=1 and oByte=byte 0 are visible in the cycle after that edge (1-cycle latency).
- Byte order is MSB first:
  - Byte 0 = iCiphertext[MSG_SIZE-1 : MSG_SIZE-8].
  - Byte k = bits [MSG_SIZE-1-8k : MSG_SIZE-8-8k].
- SEND:
  - oValid=1.
  - Transfer occurs on an edge where oValid=1 and iReady=1.
  - On a transfer: shift register moves left by 8, oByte takes the next byte, oByte_counter increments by 1.
  - With iReady held high, one byte is transferred per cycle and there are no bubbles.
  - With iReady=0: oByte, oValid and oByte_counter hold.
  - oValid never drops in SEND without a transfer.
  - oByte is stable while oValid=1 and iReady=0.
- Last byte:
  - The transfer that brings oByte_counter to MSG_SIZE/8 moves the state to DONE.
  - On that edge, oValid goes to 0 and oSend_done goes to 1 together.
- DONE:
  - Terminal until reset.
  - oValid=0; oSend_done=1; oByte_counter holds at MSG_SIZE/8.
  - iEncrypt_done remaining high does not re-trigger.
  - iReady is ignored.
- iReady behaviour in IDLE and DONE:
  - iReady=1 has no effect.
  - iReady is allowed to be high before oValid rises; the first transfer still takes a full cycle of oValid=1.
- iCiphertext:
  - Changes after the load edge are ignored.
  - It is sampled only in IDLE when iEncrypt_done=1.
- iEncrypt_done:
  - If high on the first edge after reset release, load happens on that edge.
  - Dropping it mid-SEND has no effect.
- Reset mid-SEND:
  - Aborts immediately and discards the remaining bytes; outputs go to reset values.
  - After release, a new load occurs only when iEncrypt_done is high again.
- oByte_counter width for MSG_SIZE=512 is 7 bits; it never wraps.

Test Plan:
- No backpressure:
  - Stimulus: MSG_SIZE=512, iCiphertext with byte k = k (0x00..0x3F MSB first), iReady=1, iEncrypt_done rises at cycle 10.
  - Response: oValid rises at cycle 11; oByte = 0x00,0x01,…,0x3F on cycles 11..74; oSend_done=1 and oValid=0 from cycle 75; oByte_counter=64.
- Backpressure:
  - Stimulus: same data, iReady toggles 1,0,0,1 repeating.
  - Response: each byte held stable while iReady=0; exactly 64 transfers in order; oByte_counter steps only on transfers; done after the 64th.
- Late ready:
  - Stimulus: iReady=0 for 20 cycles after load.
  - Response: oByte=0x00, oValid=1, oByte_counter=0 held for all 20 cycles; streaming proceeds once iReady=1.
- Reset mid-send:
  - Stimulus: assert iRst low between clock edges after 30 transfers.
  - Response: outputs go to 0 immediately, without waiting for a clock edge. After release with iEncrypt_done=1 and new data 0xFF..: restart from byte 0 = 0xFF, counter from 0.
- Terminal DONE:
  - Stimulus: after oSend_done, hold iEncrypt_done=1 and iReady=1, change iCiphertext for 100 cycles.
  - Response: oValid stays 0; oSend_done stays 1; oByte_counter stays 64.
- Done at reset release:
  - Stimulus: iEncrypt_done=1 already when iRst deasserts.
  - Response: load on the first edge; oValid=1 with byte 0 on the following cycle.
